// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the front-end stages: opcodes, the immediate
// select encoding consumed by the Stage2 mux4to1, the canonical NOP and the
// IF/ID register state encoding.
package riscv_pkg;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Stage2 immediate mux select; U and J share input 3 of the mux,
  // the J layout is distinguished by the separate jal flag.
  localparam logic [1:0] IMM_SEL_I  = 2'b00;
  localparam logic [1:0] IMM_SEL_S  = 2'b01;
  localparam logic [1:0] IMM_SEL_B  = 2'b10;
  localparam logic [1:0] IMM_SEL_UJ = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Pre-decode result carried alongside an instruction
  typedef struct packed {
    logic [1:0] imm_sel;
    logic       jal;
    logic       illegal;
  } predec_t;

  // Pre-decode of the NOP / an empty slot
  localparam predec_t PREDEC_NONE = '{imm_sel: IMM_SEL_I, jal: 1'b0, illegal: 1'b0};

  // IF/ID occupancy, encoded as {main_valid, skid_valid}. 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } pipe_state_e;

  // Major opcode field of an instruction word
  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/imm_sel_decode.sv
// Combinational opcode pre-decode: picks the Stage2 immediate format and
// flags JAL and unrecognised opcodes. R-type uses no immediate; it is given
// the I select so the mux input is simply ignored downstream.
module imm_sel_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_sel,
  output logic       jal,
  output logic       illegal
);

  // Opcode -> immediate format, JAL flag, illegal flag
  always_comb begin
    imm_sel = IMM_SEL_I;
    jal     = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD,
      OPC_OPIMM,
      OPC_JALR,
      OPC_SYSTEM,
      OPC_FENCE,
      OPC_OP:     imm_sel = IMM_SEL_I;
      OPC_STORE:  imm_sel = IMM_SEL_S;
      OPC_BRANCH: imm_sel = IMM_SEL_B;
      OPC_LUI,
      OPC_AUIPC:  imm_sel = IMM_SEL_UJ;
      OPC_JAL: begin
        imm_sel = IMM_SEL_UJ;
        jal     = 1'b1;
      end
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// Fetch -> decode pipeline register with a 2-entry skid buffer.
//
// Handshake: on each side a beat transfers at a rising edge where valid and
// ready are both high. A producer holds valid (and its data) until the beat
// transfers; id_* stay stable while id_valid=1 and id_ready=0. if_ready is
// the inverse of the registered skid occupancy, so there is no combinational
// path from id_ready to if_ready and the stage still sustains one beat per
// cycle: a beat that arrives while decode stalls parks in the skid entry.
//
// The opcode is pre-decoded on the fetch side and stored with the beat, so
// the Stage2 immediate select leaves this register already registered.
module if_id_pipe_reg #(
  parameter int          N         = 32,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          if_valid,
  output logic          if_ready,
  input  logic [31:0]   if_instr,
  input  logic [N-1:0]  if_pc,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_instr,
  output logic [N-1:0]  id_pc,
  output logic [1:0]    id_imm_sel,
  output logic          id_jal,
  output logic          id_illegal,
  output logic [15:0]   bubble_cnt
);

  import riscv_pkg::*;

  localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

  // Occupancy state; kept as a named enum so checkers can bind to it
  pipe_state_e state_q;
  pipe_state_e state_d;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;

  // Data-path strobes produced by the next-state logic
  logic load_main_in;
  logic load_main_skid;
  logic clear_main;
  logic load_skid;

  // Main (output) entry and skid entry payloads
  logic [31:0]  main_instr;
  logic [N-1:0] main_pc;
  predec_t      main_dec;
  logic [31:0]  skid_instr;
  logic [N-1:0] skid_pc;
  predec_t      skid_dec;

  // Pre-decode of the incoming beat
  predec_t      in_dec;

  imm_sel_decode u_imm_sel_decode (
    .opcode  (opcode_of(if_instr)),
    .imm_sel (in_dec.imm_sel),
    .jal     (in_dec.jal),
    .illegal (in_dec.illegal)
  );

  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_FULL);

  assign if_ready = !skid_valid;
  assign id_valid = main_valid;

  assign in_fire  = if_valid && if_ready;
  assign out_fire = main_valid && id_ready;

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and data-path strobes; flush overrides every handshake
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    clear_main     = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d    = ST_EMPTY;
      clear_main = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d    = ST_EMPTY;
            clear_main = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          clear_main = 1'b1;
        end
      endcase
    end
  end

  // Main entry: load from fetch, refill from skid, or fall back to the NOP.
  // The PC is left alone when emptying; it is meaningless while id_valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_instr <= NOP_INSTR;
      main_pc    <= '0;
      main_dec   <= PREDEC_NONE;
    end else if (clear_main) begin
      main_instr <= NOP_INSTR;
      main_dec   <= PREDEC_NONE;
    end else if (load_main_in) begin
      main_instr <= if_instr;
      main_pc    <= if_pc;
      main_dec   <= in_dec;
    end else if (load_main_skid) begin
      main_instr <= skid_instr;
      main_pc    <= skid_pc;
      main_dec   <= skid_dec;
    end
  end

  // Skid entry: captures a beat that arrives while decode is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
      skid_dec   <= PREDEC_NONE;
    end else if (load_skid) begin
      skid_instr <= if_instr;
      skid_pc    <= if_pc;
      skid_dec   <= in_dec;
    end
  end

  // Saturating count of cycles where decode was ready but had nothing to take
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (id_ready && !main_valid && (bubble_cnt != BUBBLE_MAX)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign id_instr   = main_instr;
  assign id_pc      = main_pc;
  assign id_imm_sel = main_dec.imm_sel;
  assign id_jal     = main_dec.jal;
  assign id_illegal = main_dec.illegal;

endmodule
